// File: rtl/tt_pin_host_pkg.sv
// Shared types and pin map for the TinyTapeout strobe/ack host sequencer.
package tt_pin_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE_WAIT,
    RELEASE,
    RESP
  } state_e;

  localparam int UIO_STRB = 0;
  localparam int UIO_ACK  = 1;
  localparam int UIO_RNW  = 2;

  localparam int TO_W = 8;

endpackage

// File: rtl/tt_sync_bit.sv
// N-flop single-bit synchronizer, synchronously cleared to 0.
module tt_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tt_pin_host.sv
// Host-side initiator for the TinyTapeout strobe/acknowledge byte handshake:
// drives ui_in/RNW, strobes, waits for ACK to rise and fall, returns uo_out.
module tt_pin_host
  import tt_pin_host_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_read,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic       busy,
  output logic [7:0] ui_in_o,
  output logic [7:0] uio_in_o,
  input  logic [7:0] uo_out_i,
  input  logic [7:0] uio_out_i,
  input  logic [7:0] uio_oe_i
);

  localparam logic [TO_W-1:0] SETUP_LIM = TO_W'(SETUP_CYC);
  localparam logic [TO_W-1:0] TO_LIM    = TO_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]      data_q, data_d;
  logic            rnw_q, rnw_d;
  logic [7:0]      cap_q, cap_d;
  logic            err_q, err_d;
  logic            ack_sync;
  logic            unused_pins;

  // ACK only counts while the project actually drives that pin.
  tt_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (uio_out_i[UIO_ACK] & uio_oe_i[UIO_ACK]),
    .q_o (ack_sync)
  );

  assign unused_pins = ^{uio_out_i[7:2], uio_out_i[0], uio_oe_i[7:2], uio_oe_i[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rnw_q   <= 1'b0;
      cap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rnw_q   <= rnw_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
    end
  end

  // The counter is compared after incrementing, so each wait state lasts
  // at most its limit in cycles; every state change restarts it at zero.
  always_comb begin
    state_d = state_q;
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rnw_d   = rnw_q;
    cap_d   = cap_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d  = cmd_data;
          rnw_d   = cmd_read;
          cap_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d = cnt_inc;
        if (cnt_inc == SETUP_LIM) begin
          cnt_d   = '0;
          state_d = STROBE_WAIT;
        end
      end
      STROBE_WAIT: begin
        cnt_d = cnt_inc;
        if (ack_sync) begin
          cap_d   = uo_out_i;
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_inc == TO_LIM) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        cnt_d = cnt_inc;
        if (!ack_sync) begin
          cnt_d   = '0;
          state_d = RESP;
        end else if (cnt_inc == TO_LIM) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    uio_in_o           = '0;
    uio_in_o[UIO_STRB] = (state_q == STROBE_WAIT);
    uio_in_o[UIO_RNW]  = rnw_q;
  end

  assign ui_in_o    = data_q;
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_data  = (resp_valid && !err_q) ? cap_q : 8'h00;

endmodule

// File: doc/tt_pin_host.md
# tt_pin_host

Host-side initiator for the strobe/acknowledge byte handshake that a TinyTapeout user project exposes on its `ui_in`/`uo_out`/`uio` pins. The block accepts byte commands on a valid/ready port, drives them onto the project's dedicated inputs, and strobes a request on `uio`. It waits for the project's acknowledge and returns the byte on `uo_out` as a response. It sits on the FPGA/bench side of the pin boundary, opposite the user project, and replaces hand-written cocotb pin wiggling with a synthesizable sequencer.

## Interface
- `SETUP_CYC`, default 1: cycles `ui_in_o` and RNW are held stable before the strobe rises (≥1).
- `TIMEOUT`, default 255: maximum cycles in each wait state before abort (8-bit counter, 1..255).
- `SYNC_STAGES`, default 2: flop depth of the ack synchronizer (≥2).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_data` in 8: byte to drive on `ui_in_o`.
- `cmd_read` in 1: 1 = read, 0 = write; driven on the RNW pin.
- `resp_valid` out 1: one-cycle pulse per completed command; no backpressure.
- `resp_data` out 8: `uo_out_i` captured at ack; 0 on error.
- `resp_err` out 1: qualifies `resp_valid`; 1 = timeout.
- `busy` out 1: high whenever the state is not IDLE.
- `ui_in_o` out 8: drives the project's `ui_in`.
- `uio_in_o` out 8: bit0 = STRB, bit2 = RNW, all other bits 0.
- `uo_out_i` in 8: from the project's `uo_out`.
- `uio_out_i` in 8: bit1 = ACK.
- `uio_oe_i` in 8: ACK is valid only when `uio_oe_i[1]` = 1.

## Operation
- The effective ack is `uio_out_i[1] & uio_oe_i[1]`, passed through the `SYNC_STAGES` synchronizer. The raw value is never used.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch `cmd_data` and `cmd_read`, then go to SETUP.
- SETUP:
  - `ui_in_o` = latched data; RNW = latched read bit; STRB = 0.
  - Stay `SETUP_CYC` cycles, then go to STROBE_WAIT.
- STROBE_WAIT:
  - STRB = 1; the timeout counter increments each cycle.
  - On sync ack = 1: capture `uo_out_i` into `resp_data`, drop STRB, go to RELEASE.
  - On count == `TIMEOUT`: set the error flag, drop STRB, go to RELEASE.
- RELEASE:
  - STRB = 0; the counter is restarted on entry.
  - On sync ack = 0: go to RESP.
  - On count == `TIMEOUT`: set the error flag, go to RESP.
- RESP:
  - `resp_valid` = 1 for exactly one cycle. `resp_err` = error flag. `resp_data` = 0 if error, else the captured byte.
  - Go to IDLE.
- `ui_in_o` and RNW hold their last value in IDLE; they change only on SETUP entry.
- Writes also return `uo_out_i` (echo/status byte).
- If ack is already high when STROBE_WAIT is entered (stale ack), the block treats it as acknowledge. The bench must not do this; it is documented behaviour, not an error.

## Timing
- Reset values:
  - State IDLE, `cmd_ready` = 1, `busy` = 0.
  - `ui_in_o` = 0, `uio_in_o` = 0, `resp_valid` = 0, `resp_err` = 0, `resp_data` = 0.
  - Synchronizer flops and counter = 0.
- Cycle numbering, with the command handshake in cycle 0:
  - `ui_in_o` is valid from cycle 1.
  - STRB rises in cycle 1+`SETUP_CYC`.
- Latency against a responder that echoes STRB combinationally as ACK, with defaults:
  - STRB high in cycles 2..4.
  - `resp_valid` in cycle 8 (ack seen 2 cycles after each edge, plus the state steps).
- Timeout: STRB stays high for exactly `TIMEOUT` cycles, then falls.
- `rst` mid-transaction:
  - STRB and all outputs return to their reset values on the next edge.
  - No `resp_valid` is emitted.
- `cmd_valid` while busy: ignored, since `cmd_ready` = 0. There is no queueing.

## Structure
- Package `tt_pin_host_pkg` holds:
  - The state enum `{IDLE, SETUP, STROBE_WAIT, RELEASE, RESP}`.
  - Pin index constants `UIO_STRB=0`, `UIO_ACK=1`, `UIO_RNW=2`.
  - Counter width constant `TO_W=8`.
- Sub-module `tt_sync_bit`: parameterized N-flop single-bit synchronizer with synchronous reset to 0. Used for ACK.
- The FSM, counter and datapath stay in `tt_pin_host`.

## Test plan
- Write echo:
  - Stimulus: `cmd_data`=0xA5, read=0. Responder acks after 3 cycles and drives `uo_out`=0x5A.
  - Response: `ui_in_o`=0xA5 before STRB; RNW=0; one `resp_valid` with data 0x5A, err=0.
- Read:
  - Stimulus: read=1, data=0x03. Responder returns 0xC3.
  - Response: RNW=1 during STRB; `resp_data`=0xC3.
- Timeout:
  - Stimulus: responder never acks, `TIMEOUT`=10.
  - Response: STRB high for exactly 10 cycles; `resp_err`=1, `resp_data`=0; back in IDLE.
- Stuck ack:
  - Stimulus: ACK never falls, `TIMEOUT`=10.
  - Response: `resp_err`=1 after 10 RELEASE cycles.
- OE gating:
  - Stimulus: `uio_out_i[1]`=1 but `uio_oe_i[1]`=0.
  - Response: no acknowledge is taken; the command times out.
- Reset mid-operation:
  - Stimulus: assert `rst` during STROBE_WAIT.
  - Response: the next cycle shows STRB=0, `busy`=0, `cmd_ready`=1, no `resp_valid`. A following command completes normally.
